hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_pkg.sv | 19 +
 rtl/load_use_detect.sv | 23 ++
 rtl/hazard_controller.sv | 167 ++++++++++++++++
 tb/tb_hazard_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-address width and default parameter values.
package hazard_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int STATE_W          = 3;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int MAX_MEM_WAIT_DEF = 15;
    localparam int CNT_W_DEF        = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN        = 3'd0,
        ST_LOAD_STALL = 3'd1,
        ST_MEM_WAIT   = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_HALTED     = 3'd4
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// feeds a source register of the instruction in ID.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic                  ex_nop,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_uses_rt,
    output logic                  hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rd_addr == id_rs_addr);
    assign rt_match = id_uses_rt & (ex_rd_addr == id_rt_addr);
    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hazard   = ex_mem_read & ~ex_nop & (ex_rd_addr != '0) & (rs_match | rt_match);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory waits
// with timeout and debug halt/drain. Define HAZ_PERF_CNT_EN to add stall_cycles.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int MAX_MEM_WAIT = MAX_MEM_WAIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_mem_read,
    input  logic                  ex_nop,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_uses_rt,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  exmem_en,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [STATE_W-1:0]    ctrl_state,
    output logic                  mem_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles
`endif
);

    localparam int WAIT_W  = $clog2(MAX_MEM_WAIT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic               timeout_reg;
    logic               timeout_set;
    logic               load_use;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_nop      (ex_nop),
        .ex_rd_addr  (ex_rd_addr),
        .id_rs_addr  (id_rs_addr),
        .id_rt_addr  (id_rt_addr),
        .id_uses_rt  (id_uses_rt),
        .hazard      (load_use)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            timeout_reg   <= timeout_reg | timeout_set;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        timeout_set    = 1'b0;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        exmem_en       = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        case (state_reg)
            ST_RUN, ST_LOAD_STALL: begin
                // LOAD_STALL skips the hazard check so a single load costs one bubble
                if (mem_busy) begin
                    pc_en         = 1'b0;
                    ifid_en       = 1'b0;
                    exmem_en      = 1'b0;
                    wait_cnt_next = '0;
                    state_next    = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_next  = ST_RUN;
                end else if (state_reg == ST_LOAD_STALL) begin
                    state_next = ST_RUN;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    state_next  = ST_LOAD_STALL;
                end else if (halt_req) begin
                    drain_cnt_next = '0;
                    state_next     = ST_DRAIN;
                end
            end
            ST_MEM_WAIT: begin
                // Enables release in the same cycle memory reports ready
                if (mem_busy) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    exmem_en = 1'b0;
                    if (wait_cnt_reg == WAIT_W'(MAX_MEM_WAIT - 1)) begin
                        timeout_set   = 1'b1;
                        wait_cnt_next = '0;
                        state_next    = ST_HALTED;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    end
                end else begin
                    wait_cnt_next = '0;
                    state_next    = ST_RUN;
                end
            end
            ST_DRAIN: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                if (mem_busy) begin
                    exmem_en = 1'b0;
                end else if (drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    drain_cnt_next = '0;
                    state_next     = ST_HALTED;
                end else begin
                    drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
                end
            end
            ST_HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                exmem_en = 1'b0;
                if (resume) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign ctrl_state  = state_reg;
    assign mem_timeout = timeout_reg;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (!pc_en && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// stimulus compared cycle by cycle against a rule-level reference model.
module tb_hazard_controller;
    import hazard_pkg::*;

    localparam int DRAIN = 3;
    localparam int MAXW  = 15;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic       mr;
        logic       nop;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       br;
        logic       busy;
        logic       halt;
        logic       res;
    } stim_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ex_mem_read, ex_nop, id_uses_rt, branch_taken, mem_busy, halt_req, resume;
    logic [4:0] ex_rd_addr, id_rs_addr, id_rt_addr;
    logic       pc_en, ifid_en, exmem_en, ifid_flush, idex_bubble, mem_timeout;
    logic [2:0] ctrl_state;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: mode plus "elapsed busy cycles" and "drain cycles left"
    state_t m_state;
    int     m_wait;
    int     m_drain_left;
    logic   m_to;
    int     m_stall;

    hazard_controller #(
        .DRAIN_CYCLES (DRAIN),
        .MAX_MEM_WAIT (MAXW),
        .CNT_W        (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_mem_read  (ex_mem_read),
        .ex_nop       (ex_nop),
        .ex_rd_addr   (ex_rd_addr),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_uses_rt   (id_uses_rt),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .exmem_en     (exmem_en),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .ctrl_state   (ctrl_state),
        .mem_timeout  (mem_timeout)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.mr   = ($urandom_range(0, 1) == 1);
        s.nop  = ($urandom_range(0, 6) == 0);
        s.rd   = 5'($urandom_range(0, 3));
        s.rs   = 5'($urandom_range(0, 3));
        s.rt   = 5'($urandom_range(0, 3));
        s.uses = ($urandom_range(0, 1) == 1);
        s.br   = ($urandom_range(0, 6) == 0);
        s.busy = ($urandom_range(0, 5) == 0);
        s.halt = ($urandom_range(0, 15) == 0);
        s.res  = ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        ex_mem_read  = s.mr;
        ex_nop       = s.nop;
        ex_rd_addr   = s.rd;
        id_rs_addr   = s.rs;
        id_rt_addr   = s.rt;
        id_uses_rt   = s.uses;
        branch_taken = s.br;
        mem_busy     = s.busy;
        halt_req     = s.halt;
        resume       = s.res;
    endtask

    function automatic bit hazard_of(input stim_t s);
        return s.mr && !s.nop && (s.rd != 0) && ((s.rd == s.rs) || (s.uses && (s.rd == s.rt)));
    endfunction

    // Expected {pc_en, ifid_en, exmem_en, ifid_flush, idex_bubble}
    function automatic logic [4:0] model_outs(input stim_t s);
        case (m_state)
            ST_RUN, ST_LOAD_STALL: begin
                if (s.busy)                               return 5'b00000;
                if (s.br)                                 return 5'b11111;
                if (m_state == ST_RUN && hazard_of(s))    return 5'b00101;
                return 5'b11100;
            end
            ST_MEM_WAIT: return s.busy ? 5'b00000 : 5'b11100;
            ST_DRAIN:    return s.busy ? 5'b00001 : 5'b00101;
            default:     return 5'b00000;
        endcase
    endfunction

    task automatic model_reset();
        m_state      = ST_RUN;
        m_wait       = 0;
        m_drain_left = 0;
        m_to         = 1'b0;
        m_stall      = 0;
    endtask

    task automatic model_advance(input stim_t s, input logic pc_exp);
        if (!pc_exp && m_stall < (2 ** CNT_W) - 1) m_stall++;
        case (m_state)
            ST_RUN: begin
                if (s.busy)              begin m_state = ST_MEM_WAIT; m_wait = 0; end
                else if (s.br)           m_state = ST_RUN;
                else if (hazard_of(s))   m_state = ST_LOAD_STALL;
                else if (s.halt)         begin m_state = ST_DRAIN; m_drain_left = DRAIN; end
            end
            ST_LOAD_STALL: begin
                if (s.busy) begin m_state = ST_MEM_WAIT; m_wait = 0; end
                else        m_state = ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (!s.busy) m_state = ST_RUN;
                else begin
                    m_wait++;
                    if (m_wait >= MAXW) begin m_to = 1'b1; m_state = ST_HALTED; end
                end
            end
            ST_DRAIN: begin
                if (!s.busy) begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_state = ST_HALTED;
                end
            end
            default: if (s.res) m_state = ST_RUN;
        endcase
    endtask

    task automatic compare_all(input stim_t s);
        logic [4:0] e;
        e = model_outs(s);
        check("enables", 32'({pc_en, ifid_en, exmem_en}), 32'(e[4:2]));
        check("flush_bubble", 32'({ifid_flush, idex_bubble}), 32'(e[1:0]));
        check("state", 32'(ctrl_state), 32'(m_state));
        check("mem_timeout", 32'(mem_timeout), 32'(m_to));
`ifdef HAZ_PERF_CNT_EN
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic step(input stim_t s);
        logic [4:0] e;
        apply(s);
        #1;
        compare_all(s);
        e = model_outs(s);
        $display("cyc %0d st=%0d busy=%0b br=%0b haz=%0b halt=%0b res=%0b -> en=%0b%0b%0b fl=%0b bub=%0b to=%0b",
                 cyc, ctrl_state, s.busy, s.br, hazard_of(s), s.halt, s.res,
                 pc_en, ifid_en, exmem_en, ifid_flush, idex_bubble, mem_timeout);
        @(posedge clock);
        model_advance(s, e[4]);
        cyc++;
        @(negedge clock);
    endtask

    // Asserts reset mid-cycle and checks the abort before any clock edge
    task automatic do_reset(input stim_t s);
        apply(s);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all(s);
        $display("cyc %0d async reset -> st=%0d to=%0b", cyc, ctrl_state, mem_timeout);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cyc++;
    endtask

    initial begin
        stim_t s;
        apply(idle());
        model_reset();
        @(negedge clock);
        do_reset(idle());

        // Load-use on rs: one bubble, one LOAD_STALL cycle, back to RUN
        s = idle(); s.mr = 1; s.rd = 5; s.rs = 5; s.rt = 9; step(s);
        s = idle(); s.nop = 1; s.mr = 1; s.rd = 5; s.rs = 5; step(s);
        step(idle());
        // Load to r0 and rt match without rt use: no stall
        s = idle(); s.mr = 1; s.rd = 0; s.rs = 0; step(s);
        s = idle(); s.mr = 1; s.rd = 7; s.rs = 1; s.rt = 7; s.uses = 0; step(s);
        s.uses = 1; step(s);
        step(idle());
        // Branch together with hazard: flush only
        s = idle(); s.mr = 1; s.rd = 3; s.rs = 3; s.br = 1; step(s);
        step(idle());
        // Memory busy for 4 cycles
        s = idle(); s.busy = 1;
        for (int i = 0; i < 4; i++) step(s);
        step(idle());
        // Halt: drain then HALTED, resume
        s = idle(); s.halt = 1; step(s);
        for (int i = 0; i < DRAIN + 1; i++) step(idle());
        s = idle(); s.res = 1; step(s);
        step(idle());
        // Busy during drain freezes the drain count
        s = idle(); s.halt = 1; step(s);
        step(idle());
        s = idle(); s.busy = 1; step(s); step(s);
        for (int i = 0; i < DRAIN; i++) step(idle());
        s = idle(); s.res = 1; step(s);
        // Memory busy for 16 cycles: timeout and HALTED
        s = idle(); s.busy = 1;
        for (int i = 0; i < 16; i++) step(s);
        step(idle());
        s = idle(); s.res = 1; step(s);
        // Reset while in MEM_WAIT with the timeout flag set
        s = idle(); s.busy = 1; step(s); step(s);
        do_reset(s);
        step(idle());

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 60) == 0) begin
                do_reset(rnd());
            end else if ($urandom_range(0, 40) == 0) begin
                int len;
                len = $urandom_range(10, 18);
                for (int k = 0; k < len; k++) begin
                    s = rnd(); s.busy = 1; step(s);
                end
            end else begin
                step(rnd());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
